// File: rtl/rotate_sequencer_pkg.sv
// Shared types and widths for the rotate sequencer and its companion rotator.
package rotate_sequencer_pkg;

    localparam int DATA_W    = 8;
    localparam int AMT_W     = 3;
    // Command count field is wide enough for any supported CNT_W; narrower counts are zero-extended.
    localparam int CMD_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [AMT_W-1:0]     step;
        logic                 dir;
        logic [CMD_CNT_W-1:0] count;
    } cmd_t;

endpackage

// File: rtl/barrel_rotator.sv
// Purely combinational 8-bit barrel rotator; dir=0 rotates left, dir=1 rotates right.
module barrel_rotator
    import rotate_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    output logic [DATA_W-1:0] y
);

    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] shifted;

    // Shifting a doubled copy makes the wrapped bits fall into the kept half.
    always_comb begin
        dbl     = {a, a};
        shifted = dir ? (dbl >> amt) : (dbl << amt);
        y       = dir ? shifted[DATA_W-1:0] : shifted[2*DATA_W-1:DATA_W];
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Command-driven sequencer: feeds an external rotator with an accumulating amount
// and streams each rotated result out over valid/ready.
module rotate_sequencer
    import rotate_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_step,
    input  logic              in_dir,
    input  logic [CNT_W-1:0]  in_count,
    output logic [DATA_W-1:0] sh_a,
    output logic [AMT_W-1:0]  sh_amt,
    output logic              sh_dir,
    input  logic [DATA_W-1:0] sh_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output state_e            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and a producer holds its payload until the transfer.

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [AMT_W-1:0]    acc_amt_q, acc_amt_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic                capture;
    logic                last_k;

    assign last_k  = (CMD_CNT_W'(k_q) == cmd_q.count);
    assign capture = (state_q == RUN) && (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        acc_amt_d   = acc_amt_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cmd_d.data  = in_data;
                        cmd_d.step  = in_step;
                        cmd_d.dir   = in_dir;
                        cmd_d.count = CMD_CNT_W'(in_count);
                        acc_amt_d   = '0;
                        k_d         = '0;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        out_data_d  = sh_y;
                        out_valid_d = 1'b1;
                        out_last_d  = last_k;
                        k_d         = k_q + CNT_W'(1);
                        acc_amt_d   = acc_amt_q + cmd_q.step;
                        if (last_k) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            acc_amt_q   <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            acc_amt_q   <= acc_amt_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Rotator inputs come straight from registers, so sh_y never reaches in_ready.
    assign sh_a      = cmd_q.data;
    assign sh_amt    = acc_amt_q;
    assign sh_dir    = cmd_q.dir;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == RUN) || out_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Self-checking bench for rotate_sequencer wired to barrel_rotator, scoreboard-based.
module tb_rotate_sequencer;
    import rotate_sequencer_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic [2:0]       in_step = '0;
    logic             in_dir = 1'b0;
    logic [CNT_W-1:0] in_count = '0;
    logic [7:0]       sh_a;
    logic [2:0]       sh_amt;
    logic             sh_dir;
    logic [7:0]       sh_y;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    state_e           dbg_state;

    rotate_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_step(in_step), .in_dir(in_dir), .in_count(in_count),
        .sh_a(sh_a), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_y(sh_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .dbg_state(dbg_state)
    );

    barrel_rotator u_rot (
        .a(sh_a), .amt(sh_amt), .dir(sh_dir), .y(sh_y)
    );

    always #5 clk = ~clk;

    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       stall_seen = 1'b0;
    logic [7:0] stall_data = '0;

    // Reference rotation one bit at a time.
    function automatic logic [7:0] rot_ref(input logic [7:0] a, input int amt, input logic dir);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < amt; i++) begin
            r = dir ? {r[0], r[7:1]} : {r[6:0], r[7]};
        end
        return r;
    endfunction

    // Scoreboard monitor: samples on the falling edge, a transfer completes at the next rising edge.
    always @(negedge clk) begin
        logic [8:0] exp_v;
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && out_valid) begin
                n_checks++;
                if (out_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: out_data=%02h required=%02h", out_data, stall_data);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: data=%02h last=%0b with empty queue", out_data, out_last);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_v) begin
                        n_fail++;
                        $display("FAIL result: last/data=%0b/%02h required=%0b/%02h",
                                 out_last, out_data, exp_v[8], exp_v[7:0]);
                    end
                end
                stall_seen = 1'b0;
            end else if (out_valid) begin
                stall_seen = 1'b1;
                stall_data = out_data;
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic [7:0] d, input logic [2:0] s, input logic dr, input logic [3:0] c);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_step  = s;
        in_dir   = dr;
        in_count = c;
        for (int k = 0; k <= int'(c); k++) begin
            exp_q.push_back({(k == int'(c)), rot_ref(d, (int'(s) * k) % 8, dr)});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit chk_busy);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < 400) begin
            if (chk_busy && exp_q.size() != 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_busy: busy=%0b required=1", name, busy);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: pending=%0d busy=%0b required 0/0", name, exp_q.size(), busy);
        end
        n_checks++;
        if (in_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s_idle: in_ready=%0b state=%0d required 1/IDLE", name, in_ready, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid/data/last=%0b/%02h/%0b required 0/00/0", out_valid, out_data, out_last);
        end
        n_checks++;
        if (sh_a !== 8'h00 || sh_amt !== 3'd0 || sh_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sh: a/amt/dir=%02h/%0d/%0b required 00/0/0", sh_a, sh_amt, sh_dir);
        end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_ctl: in_ready/busy/state=%0b/%0b/%0d required 1/0/IDLE", in_ready, busy, dbg_state);
        end
    endtask

    task automatic test_walk();
        out_ready = 1'b1;
        send_cmd(8'h01, 3'd1, 1'b0, 4'd7);
        n_checks++;
        if (out_valid !== 1'b0 || dbg_state !== RUN) begin
            n_fail++;
            $display("FAIL walk_first_latency: valid/state=%0b/%0d required 0/RUN", out_valid, dbg_state);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL walk_consecutive[%0d]: out_valid=%0b required=1", i, out_valid);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL walk_end: valid/busy/in_ready/pending=%0b/%0b/%0b/%0d required 0/0/1/0",
                     out_valid, busy, in_ready, exp_q.size());
        end
    endtask

    task automatic test_right_step3();
        send_cmd(8'h81, 3'd3, 1'b1, 4'd2);
        wait_drain("right3", 1'b0);
    endtask

    task automatic test_amount_wrap();
        send_cmd(8'h01, 3'd5, 1'b0, 4'd3);
        wait_drain("wrap", 1'b0);
    endtask

    task automatic test_backpressure();
        bit done;
        done = 1'b0;
        send_cmd(8'h01, 3'd1, 1'b0, 4'd7);
        fork
            begin
                wait_drain("backpressure", 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
    endtask

    task automatic test_count0_step0();
        send_cmd(8'hA5, 3'd2, 1'b0, 4'd0);
        wait_drain("count0", 1'b0);
        send_cmd(8'hA5, 3'd0, 1'b1, 4'd3);
        wait_drain("step0", 1'b0);
    endtask

    task automatic test_full_count();
        send_cmd(8'h5C, 3'd3, 1'b1, 4'hF);
        wait_drain("full_count", 1'b0);
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_cmd(8'h01, 3'd1, 1'b0, 4'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ctl: valid/last/in_ready/busy=%0b/%0b/%0b/%0b required 0/0/1/0",
                     out_valid, out_last, in_ready, busy);
        end
        n_checks++;
        if (out_data !== 8'h04 || exp_q.size() != 5) begin
            n_fail++;
            $display("FAIL flush_hold: data=%02h pending=%0d required 04/5", out_data, exp_q.size());
        end
        exp_q.delete();
        send_cmd(8'h81, 3'd3, 1'b1, 4'd2);
        wait_drain("after_flush", 1'b0);
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b0;
        send_cmd(8'h01, 3'd1, 1'b0, 4'd7);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset_out: valid/data/last/busy/in_ready=%0b/%02h/%0b/%0b/%0b required 0/00/0/0/1",
                     out_valid, out_data, out_last, busy, in_ready);
        end
        n_checks++;
        if (sh_a !== 8'h00 || sh_amt !== 3'd0 || sh_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_sh: a/amt/dir=%02h/%0d/%0b required 00/0/0", sh_a, sh_amt, sh_dir);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL midrun_no_resume: valid/state=%0b/%0d required 0/IDLE", out_valid, dbg_state);
        end
        send_cmd(8'h3C, 3'd2, 1'b0, 4'd1);
        wait_drain("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_walk();
        test_right_step3();
        test_amount_wrap();
        test_backpressure();
        test_count0_step0();
        test_full_count();
        test_flush();
        test_reset_midrun();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
